// File: rtl/usb_tx_bit_sequencer.sv
// Sequences load/shift strobes for the USB 1.1 TX shift register, one bit time per
// CLKS_PER_BIT clocks, inserting stuff periods after six 1s and generating the EOP.
module usb_tx_bit_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       sr_load,
    output logic [7:0] sr_data,
    output logic       sr_shift,
    output logic       stuff_zero,
    output logic       tx_se0,
    output logic       tx_busy,
    output logic       tx_err
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TimerMax = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StSend, StStuff, StEopSe0, StEopJ} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] bit_timer_q, bit_timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [2:0]    ones_cnt_q, ones_cnt_d;
    logic          last_q, last_d;
    logic [7:0]    cur_byte_q, cur_byte_d;
    logic          byte_done_q, byte_done_d;

    logic       period_end, boundary, cur_bit;
    logic [2:0] ones_inc;
    logic       ready_c, load_c, shift_c, err_c;

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        ones_cnt_d  = ones_cnt_q;
        last_d      = last_q;
        cur_byte_d  = cur_byte_q;
        byte_done_d = byte_done_q;
        ready_c     = 1'b0;
        load_c      = 1'b0;
        shift_c     = 1'b0;
        err_c       = 1'b0;
        boundary    = 1'b0;

        period_end  = (bit_timer_q == TimerMax);
        if (state_q == StIdle || period_end) begin
            bit_timer_d = '0;
        end else begin
            bit_timer_d = bit_timer_q + TW'(1);
        end

        cur_bit  = cur_byte_q[bit_idx_q];
        ones_inc = !cur_bit ? 3'd0 : (ones_cnt_q == 3'd6) ? 3'd6 : ones_cnt_q + 3'd1;

        unique case (state_q)
            StIdle: begin
                ready_c = 1'b1;
                if (byte_valid) begin
                    load_c      = 1'b1;
                    cur_byte_d  = byte_data;
                    last_d      = byte_last;
                    bit_idx_d   = 3'd0;
                    ones_cnt_d  = 3'd0;
                    byte_done_d = 1'b0;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (period_end) begin
                    ones_cnt_d = ones_inc;
                    if (ones_inc == 3'd6) begin
                        state_d    = StStuff;
                        ones_cnt_d = 3'd0;
                        if (bit_idx_q == 3'd7) begin
                            byte_done_d = 1'b1;
                        end else begin
                            shift_c   = 1'b1;
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else if (bit_idx_q != 3'd7) begin
                        shift_c   = 1'b1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end
            StStuff: begin
                if (period_end) begin
                    if (byte_done_q) begin
                        boundary = 1'b1;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StEopSe0: begin
                // bit_idx counts the two SE0 bit times
                if (period_end) begin
                    if (bit_idx_q == 3'd1) begin
                        bit_idx_d = 3'd0;
                        state_d   = StEopJ;
                    end else begin
                        bit_idx_d = 3'd1;
                    end
                end
            end
            StEopJ: begin
                if (period_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (boundary) begin
            if (last_q) begin
                state_d   = StEopSe0;
                bit_idx_d = 3'd0;
            end else begin
                ready_c = 1'b1;
                if (byte_valid) begin
                    load_c      = 1'b1;
                    cur_byte_d  = byte_data;
                    last_d      = byte_last;
                    bit_idx_d   = 3'd0;
                    byte_done_d = 1'b0;
                    state_d     = StSend;
                end else begin
                    err_c     = 1'b1;
                    bit_idx_d = 3'd0;
                    state_d   = StEopSe0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_timer_q <= '0;
            bit_idx_q   <= 3'd0;
            ones_cnt_q  <= 3'd0;
            last_q      <= 1'b0;
            cur_byte_q  <= 8'd0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_timer_q <= bit_timer_d;
            bit_idx_q   <= bit_idx_d;
            ones_cnt_q  <= ones_cnt_d;
            last_q      <= last_d;
            cur_byte_q  <= cur_byte_d;
            byte_done_q <= byte_done_d;
        end
    end

    // Gate strobes with rst so nothing fires in the cycle reset asserts
    assign byte_ready = ready_c & ~rst;
    assign sr_load    = load_c & ~rst;
    assign sr_shift   = shift_c & ~rst;
    assign tx_err     = err_c & ~rst;
    assign sr_data    = byte_data;
    assign stuff_zero = (state_q == StStuff);
    assign tx_se0     = (state_q == StEopSe0);
    assign tx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_usb_tx_bit_sequencer.sv
// Bench for usb_tx_bit_sequencer: per-cycle comparison against a bit-time timeline model
// built from packet bytes, plus reset scenarios.
module tb_usb_tx_bit_sequencer;

    localparam int unsigned CPB  = 8;
    localparam int          MAXC = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_ready, sr_load, sr_shift, stuff_zero, tx_se0, tx_busy, tx_err;
    logic [7:0] sr_data;

    int checks = 0;
    int errors = 0;

    // Vector bits: {ready, load, shift, stuff, se0, busy, err}
    logic [6:0] exp_v [MAXC];
    logic [7:0] exp_b [MAXC];
    logic [7:0] pkt [$];

    usb_tx_bit_sequencer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .sr_load    (sr_load),
        .sr_data    (sr_data),
        .sr_shift   (sr_shift),
        .stuff_zero (stuff_zero),
        .tx_se0     (tx_se0),
        .tx_busy    (tx_busy),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs_vec();
        return {byte_ready, sr_load, sr_shift, stuff_zero, tx_se0, tx_busy, tx_err};
    endfunction

    // Timeline of bit periods: index 0 is the first load cycle.
    task automatic build_model(input bit underrun, output int total);
        int         c, ones, n, e;
        logic [7:0] cur;
        n = pkt.size();
        for (int k = 0; k < MAXC; k++) begin
            exp_v[k] = 7'b1000000;
            exp_b[k] = 8'h00;
        end
        exp_v[0] = 7'b1100000;
        exp_b[0] = pkt[0];
        c = 0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            cur = pkt[i];
            for (int bi = 0; bi < 8; bi++) begin
                for (int j = 1; j <= CPB; j++) exp_v[c+j] = 7'b0000010;
                e = c + CPB;
                ones = cur[bi] ? ones + 1 : 0;
                if (bi < 7) exp_v[e] = exp_v[e] | 7'b0010000;
                if (ones == 6) begin
                    for (int j = 1; j <= CPB; j++) exp_v[e+j] = 7'b0001010;
                    ones = 0;
                    c = e + CPB;
                end else begin
                    c = e;
                end
            end
            if (i < n - 1) begin
                exp_v[c] = exp_v[c] | 7'b1100000;
                exp_b[c] = pkt[i+1];
            end else if (underrun) begin
                exp_v[c] = exp_v[c] | 7'b1000001;
            end
        end
        for (int j = 1; j <= 2 * CPB; j++) exp_v[c+j] = 7'b0000110;
        for (int j = 2 * CPB + 1; j <= 3 * CPB; j++) exp_v[c+j] = 7'b0000010;
        total = c + 3 * CPB + 1;
    endtask

    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_packet(input string name, input bit underrun);
        int         total, idx;
        bit         xfer;
        logic [6:0] o;
        build_model(underrun, total);
        idx        = 0;
        byte_valid = 1'b1;
        byte_data  = pkt[0];
        byte_last  = (pkt.size() == 1) && !underrun;
        for (int k = 0; k < total + 3; k++) begin
            @(negedge clk);
            o = obs_vec();
            checks++;
            if (o !== exp_v[k]) begin
                errors++;
                $display("FAIL %s cycle %0d: got rdy/ld/sh/stf/se0/bsy/err=%b expected %b",
                         name, k, o, exp_v[k]);
            end
            if (exp_v[k][5] && sr_load) begin
                checks++;
                if (sr_data !== exp_b[k]) begin
                    errors++;
                    $display("FAIL %s sr_data cycle %0d: got %h expected %h",
                             name, k, sr_data, exp_b[k]);
                end
            end
            xfer = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            if (xfer) begin
                idx++;
                if (idx < pkt.size()) begin
                    byte_data = pkt[idx];
                    byte_last = (idx == pkt.size() - 1) && !underrun;
                end else begin
                    byte_valid = 1'b0;
                    byte_last  = 1'b0;
                    byte_data  = 8'($urandom());
                end
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        byte_last  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== 7'b0 || sr_data !== byte_data) begin
                errors++;
                $display("FAIL reset_outputs: got %b data %h expected 0000000 data %h",
                         obs_vec(), sr_data, byte_data);
            end
        end
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0",
                     byte_ready, tx_busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_0x80();
        pkt = '{8'h80};
        run_packet("single_0x80", 1'b0);
    endtask

    task automatic test_stuff_3f_00();
        pkt = '{8'h3F, 8'h00};
        run_packet("stuff_3f_00", 1'b0);
    endtask

    task automatic test_ff();
        pkt = '{8'hFF};
        run_packet("byte_ff", 1'b0);
    endtask

    task automatic test_back_to_back();
        pkt = '{8'hF0, 8'hFF, 8'h01};
        run_packet("back_to_back", 1'b0);
    endtask

    task automatic test_underrun();
        pkt = '{8'h55};
        run_packet("underrun", 1'b1);
    endtask

    task automatic test_random();
        int n;
        bit ur;
        for (int p = 0; p < 16; p++) begin
            n = $urandom_range(1, 4);
            pkt.delete();
            // OR of two draws biases toward long runs of 1s
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom() | $urandom()));
            ur = ($urandom_range(0, 5) == 0);
            run_packet($sformatf("random_%0d", p), ur);
        end
    endtask

    task automatic test_mid_reset();
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        byte_last  = 1'b1;
        for (int k = 0; k < 29; k++) begin
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
        end
        checks++;
        if (tx_busy !== 1'b1 || tx_se0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_pre: got busy=%b se0=%b expected busy=1 se0=0",
                     tx_busy, tx_se0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset_assert: got %b expected 0000000", obs_vec());
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (obs_vec() !== 7'b0) begin
                errors++;
                $display("FAIL mid_reset_hold: got %b expected 0000000", obs_vec());
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release: got ready=%b busy=%b expected ready=1 busy=0",
                     byte_ready, tx_busy);
        end
        for (int k = 0; k < 3 * CPB + 2; k++) begin
            @(negedge clk);
            checks++;
            if (tx_se0 !== 1'b0 || tx_busy !== 1'b0 || sr_shift !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_no_eop: got se0=%b busy=%b shift=%b expected 0 0 0",
                         tx_se0, tx_busy, sr_shift);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single_0x80();
        test_stuff_3f_00();
        test_ff();
        test_back_to_back();
        test_underrun();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
